hazard_control_unit: RTL



---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_control_unit_if.sv | 56 +++++
 rtl/hazard_perf_counters.sv | 35 +++
 rtl/hazard_control_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard control unit.
//   - REG_ADDR_W_DEF : default register index width
//   - PERF_W         : width of the performance counters
//   - state_t        : sequencer state encoding
package hazard_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int PERF_W         = 32;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MEMWAIT = 2'd1,
        S_MULDIV  = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle of hazard inputs from the pipeline and control outputs back to it.
//   master : pipeline side (drives hazard sources, receives enables/flushes)
//   slave  : hazard control unit side
// Signals: ID source regs + use flags, EX destination / load / branch /
// mul-div start, mul-div done, dmem stall; per-register enables, flushes,
// mul-div busy/timeout status and three performance counters.
interface hazard_control_unit_if
#(
    parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W_DEF
);
    import hazard_pkg::*;

    logic [REG_ADDR_W-1:0] rs1_id;
    logic [REG_ADDR_W-1:0] rs2_id;
    logic                  rs1_used_id;
    logic                  rs2_used_id;
    logic [REG_ADDR_W-1:0] rd_ex;
    logic                  mem_read_ex;
    logic                  branch_taken_ex;
    logic                  muldiv_start_ex;
    logic                  muldiv_done;
    logic                  dmem_stall;

    logic                  pc_en;
    logic                  if_id_en;
    logic                  id_ex_en;
    logic                  ex_mem_en;
    logic                  mem_wb_en;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  ex_mem_flush;
    logic                  muldiv_busy;
    logic                  muldiv_timeout;
    logic [PERF_W-1:0]     perf_load_use;
    logic [PERF_W-1:0]     perf_muldiv_cyc;
    logic [PERF_W-1:0]     perf_flush;

    modport master (
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
               branch_taken_ex, muldiv_start_ex, muldiv_done, dmem_stall,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush,
               muldiv_busy, muldiv_timeout,
               perf_load_use, perf_muldiv_cyc, perf_flush
    );

    modport slave (
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
               branch_taken_ex, muldiv_start_ex, muldiv_done, dmem_stall,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush,
               muldiv_busy, muldiv_timeout,
               perf_load_use, perf_muldiv_cyc, perf_flush
    );

endinterface

// File: rtl/hazard_perf_counters.sv
// Three free-running, wrapping performance counters for the hazard unit.
// Only compiled when HAZARD_PERF_CNT_EN is defined.
//   clk, rst_n                     : clock, async active-low reset
//   inc_load_use/inc_muldiv/inc_flush : one-cycle increment strobes
//   perf_load_use/perf_muldiv_cyc/perf_flush : counter values
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_counters
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_load_use,
    input  logic              inc_muldiv,
    input  logic              inc_flush,
    output logic [PERF_W-1:0] perf_load_use,
    output logic [PERF_W-1:0] perf_muldiv_cyc,
    output logic [PERF_W-1:0] perf_flush
);

    localparam logic [PERF_W-1:0] ONE = PERF_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_load_use   <= '0;
            perf_muldiv_cyc <= '0;
            perf_flush      <= '0;
        end else begin
            if (inc_load_use) perf_load_use   <= perf_load_use + ONE;
            if (inc_muldiv)   perf_muldiv_cyc <= perf_muldiv_cyc + ONE;
            if (inc_flush)    perf_flush      <= perf_flush + ONE;
        end
    end

endmodule
`endif

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage RV32 core. Resolves load-use hazards,
// multi-cycle mul/div occupancy, data-memory wait states and EX redirects
// by driving per-register enables and flushes.
//   clk, rst_n : core clock, async active-low reset
//   hz         : hazard_control_unit_if.slave (hazard inputs, controls,
//                mul/div status, performance counters)
// Optional feature macro: HAZARD_PERF_CNT_EN (perf counters; tied to 0
// when undefined).
//
// state     | meaning
// S_RUN     | normal flow; redirects and load-use bubbles handled here
// S_MEMWAIT | data memory busy; freeze held until dmem_stall drops
// S_MULDIV  | mul/div occupying EX; front stages frozen, watchdog running
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W        = REG_ADDR_W_DEF,
    parameter int MULDIV_MAX_CYCLES = 34,
    parameter int CNT_W             = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_control_unit_if.slave hz
);

    localparam logic [REG_ADDR_W-1:0] RD_ZERO = '0;
    localparam logic [CNT_W-1:0]      WD_MAX  = CNT_W'(MULDIV_MAX_CYCLES);
    localparam logic [CNT_W-1:0]      WD_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt;
    logic             done_pend, done_pend_nxt;
    logic             timeout_q, timeout_set;
    logic             load_use, done_eff;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush;

    assign load_use = hz.mem_read_ex && (hz.rd_ex != RD_ZERO) &&
                      ((hz.rs1_used_id && (hz.rs1_id == hz.rd_ex)) ||
                       (hz.rs2_used_id && (hz.rs2_id == hz.rd_ex)));

    // A done pulse that arrived while dmem was stalling is remembered.
    assign done_eff = hz.muldiv_done || done_pend;

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        state_nxt     = state;
        wd_cnt_nxt    = wd_cnt;
        done_pend_nxt = done_pend;
        timeout_set   = 1'b0;

        if (state == S_MULDIV) begin
            if (hz.dmem_stall) begin
                // Whole pipe holds; the MEM instruction must not be flushed.
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_en     = 1'b0;
                mem_wb_en     = 1'b0;
                done_pend_nxt = done_eff;
                if (wd_cnt != WD_MAX) wd_cnt_nxt = wd_cnt + WD_ONE;
            end else if (done_eff) begin
                state_nxt     = S_RUN;
                wd_cnt_nxt    = '0;
                done_pend_nxt = 1'b0;
            end else if (wd_cnt == WD_MAX) begin
                // Watchdog expiry: release the pipe and flag the error.
                timeout_set   = 1'b1;
                state_nxt     = S_RUN;
                wd_cnt_nxt    = '0;
                done_pend_nxt = 1'b0;
            end else begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
                wd_cnt_nxt   = wd_cnt + WD_ONE;
            end
        end else begin
            // S_MEMWAIT with the stall released behaves exactly as S_RUN.
            if (hz.dmem_stall) begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                state_nxt = S_MEMWAIT;
            end else if (hz.muldiv_start_ex) begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_flush  = 1'b1;
                state_nxt     = S_MULDIV;
                wd_cnt_nxt    = WD_ONE;
                done_pend_nxt = 1'b0;
            end else if (hz.branch_taken_ex) begin
                // Redirect squashes the wrong-path instruction that would
                // otherwise have caused the load-use bubble.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_nxt   = S_RUN;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
                state_nxt   = S_RUN;
            end else begin
                state_nxt = S_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            wd_cnt    <= '0;
            done_pend <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wd_cnt    <= wd_cnt_nxt;
            done_pend <= done_pend_nxt;
            timeout_q <= timeout_q || timeout_set;
        end
    end

    assign hz.pc_en          = pc_en;
    assign hz.if_id_en       = if_id_en;
    assign hz.id_ex_en       = id_ex_en;
    assign hz.ex_mem_en      = ex_mem_en;
    assign hz.mem_wb_en      = mem_wb_en;
    assign hz.if_id_flush    = if_id_flush;
    assign hz.id_ex_flush    = id_ex_flush;
    assign hz.ex_mem_flush   = ex_mem_flush;
    assign hz.muldiv_busy    = (state == S_MULDIV);
    assign hz.muldiv_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic run_rules, lu_bubble, redirect;

    assign run_rules = (state != S_MULDIV) && !hz.dmem_stall && !hz.muldiv_start_ex;
    assign redirect  = run_rules && hz.branch_taken_ex;
    assign lu_bubble = run_rules && !hz.branch_taken_ex && load_use;

    hazard_perf_counters u_perf (
        .clk             (clk),
        .rst_n           (rst_n),
        .inc_load_use    (lu_bubble),
        .inc_muldiv      (state == S_MULDIV),
        .inc_flush       (redirect),
        .perf_load_use   (hz.perf_load_use),
        .perf_muldiv_cyc (hz.perf_muldiv_cyc),
        .perf_flush      (hz.perf_flush)
    );
`else
    assign hz.perf_load_use   = '0;
    assign hz.perf_muldiv_cyc = '0;
    assign hz.perf_flush      = '0;
`endif

endmodule
